// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between IF and MEM stages with wait states
module mem_port_arbiter #(
   parameter int WAIT_STATES = 2,
   parameter int AW          = 32,
   parameter int DW          = 32
) (
   input  logic          Clock,
   input  logic          Reset,
   input  logic          IF_Req,
   input  logic [AW-1:0] IF_Addr,
   output logic [DW-1:0] IF_RData,
   output logic          IF_Ack,
   input  logic          MEM_Req,
   input  logic          MEM_We,
   input  logic [AW-1:0] MEM_Addr,
   input  logic [DW-1:0] MEM_WData,
   input  logic [1:0]    MEM_ByteSel,
   output logic [DW-1:0] MEM_RData,
   output logic          MEM_Ack,
   output logic          Stall,
   output logic          Mem_En,
   output logic          Mem_We,
   output logic [AW-1:0] Mem_Addr,
   output logic [DW-1:0] Mem_WData,
   output logic [1:0]    Mem_ByteSel,
   input  logic [DW-1:0] Mem_RData
);
   localparam logic [3:0] WS = 4'(WAIT_STATES);

   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM} state_t;

   state_t     state, state_next;
   logic [3:0] cnt, cnt_next;
   logic       last_mem;
   logic       we_lat;
   logic       done, elig_if, elig_mem, pick_if, pick_mem;
   logic       en_next, we_next;

   assign Stall = (IF_Req & ~IF_Ack) | (MEM_Req & ~MEM_Ack);

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // The requester finishing this edge still holds Req high, so only the other side is eligible.
   always_comb begin
      done       = (state != IDLE) && (cnt == 4'd0);
      elig_if    = IF_Req  && ((state == IDLE) || (done && state == BUSY_MEM));
      elig_mem   = MEM_Req && ((state == IDLE) || (done && state == BUSY_IF));
      pick_mem   = elig_mem && !(last_mem && elig_if);
      pick_if    = elig_if && !pick_mem;
      state_next = state;
      cnt_next   = cnt;
      if (pick_mem) begin
         state_next = BUSY_MEM;
         cnt_next   = WS;
      end else if (pick_if) begin
         state_next = BUSY_IF;
         cnt_next   = WS;
      end else if (done) begin
         state_next = IDLE;
      end else if (state != IDLE) begin
         cnt_next = cnt - 4'd1;
      end
   end

   // Write strobe is registered, so it is raised on the edge that moves cnt to zero.
   always_comb begin
      en_next = (state_next != IDLE);
      we_next = 1'b0;
      if (pick_mem) begin
         we_next = MEM_We && (WS == 4'd0);
      end else if (state == BUSY_MEM && cnt == 4'd1) begin
         we_next = we_lat;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         IF_Ack      <= 1'b0;
         MEM_Ack     <= 1'b0;
         IF_RData    <= '0;
         MEM_RData   <= '0;
         Mem_En      <= 1'b0;
         Mem_We      <= 1'b0;
         Mem_Addr    <= '0;
         Mem_WData   <= '0;
         Mem_ByteSel <= 2'b00;
         last_mem    <= 1'b0;
         we_lat      <= 1'b0;
      end else begin
         Mem_En  <= en_next;
         Mem_We  <= we_next;
         IF_Ack  <= done && (state == BUSY_IF);
         MEM_Ack <= done && (state == BUSY_MEM);
         if (done && state == BUSY_IF) begin
            IF_RData <= Mem_RData;
         end
         if (done && state == BUSY_MEM) begin
            MEM_RData <= Mem_RData;
         end
         if (pick_mem) begin
            Mem_Addr    <= MEM_Addr;
            Mem_WData   <= MEM_WData;
            Mem_ByteSel <= MEM_ByteSel;
            we_lat      <= MEM_We;
            last_mem    <= 1'b1;
         end else if (pick_if) begin
            Mem_Addr    <= IF_Addr;
            Mem_WData   <= '0;
            Mem_ByteSel <= 2'b00;
            we_lat      <= 1'b0;
            last_mem    <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized and directed bench for mem_port_arbiter
module tb_mem_port_arbiter;
   localparam int WS    = 2;
   localparam int LIMIT = 2 * WS + 6;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset;
   logic        if_req, if_ack, d_req, d_we, d_ack, stall, m_en, m_we;
   logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, m_addr, m_wdata, m_rdata;
   logic [1:0]  d_bsel, m_bsel;

   logic        z_if_req, z_if_ack, z_d_req, z_d_we, z_d_ack, z_stall, z_m_en, z_m_we;
   logic [31:0] z_if_addr, z_if_rdata, z_d_addr, z_d_wdata, z_d_rdata, z_m_addr, z_m_wdata, z_m_rdata;
   logic [1:0]  z_d_bsel, z_m_bsel;

   int checks = 0;
   int errors = 0;

   mem_port_arbiter #(.WAIT_STATES(WS), .AW(32), .DW(32)) dut (
      .Clock(clock), .Reset(reset),
      .IF_Req(if_req), .IF_Addr(if_addr), .IF_RData(if_rdata), .IF_Ack(if_ack),
      .MEM_Req(d_req), .MEM_We(d_we), .MEM_Addr(d_addr), .MEM_WData(d_wdata),
      .MEM_ByteSel(d_bsel), .MEM_RData(d_rdata), .MEM_Ack(d_ack), .Stall(stall),
      .Mem_En(m_en), .Mem_We(m_we), .Mem_Addr(m_addr), .Mem_WData(m_wdata),
      .Mem_ByteSel(m_bsel), .Mem_RData(m_rdata)
   );

   mem_port_arbiter #(.WAIT_STATES(0), .AW(32), .DW(32)) dut_ws0 (
      .Clock(clock), .Reset(reset),
      .IF_Req(z_if_req), .IF_Addr(z_if_addr), .IF_RData(z_if_rdata), .IF_Ack(z_if_ack),
      .MEM_Req(z_d_req), .MEM_We(z_d_we), .MEM_Addr(z_d_addr), .MEM_WData(z_d_wdata),
      .MEM_ByteSel(z_d_bsel), .MEM_RData(z_d_rdata), .MEM_Ack(z_d_ack), .Stall(z_stall),
      .Mem_En(z_m_en), .Mem_We(z_m_we), .Mem_Addr(z_m_addr), .Mem_WData(z_m_wdata),
      .Mem_ByteSel(z_m_bsel), .Mem_RData(z_m_rdata)
   );

   function automatic logic [31:0] init_word(input int idx);
      if (idx == 4) return 32'h2108_000A;
      return 32'h1000_0000 ^ (32'(idx) * 32'h9E37_79B1);
   endfunction

   // Word-addressed memory macro: untouched words read their initial pattern.
   logic [31:0] ram [0:63];
   logic [63:0] written;
   always @(posedge clock) begin
      if (reset) begin
         written <= '0;
      end else if (m_we) begin
         ram[m_addr[7:2]]     <= m_wdata;
         written[m_addr[7:2]] <= 1'b1;
      end
   end
   always_comb m_rdata = written[m_addr[7:2]] ? ram[m_addr[7:2]] : init_word(int'(m_addr[7:2]));

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      checks++;
      if ({if_ack, d_ack, m_en, m_we, stall, if_rdata, d_rdata, m_addr, m_wdata, m_bsel} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got en=%b we=%b ack=%b/%b addr=%h wdata=%h exp all zero",
                  m_en, m_we, if_ack, d_ack, m_addr, m_wdata);
      end
      checks++;
      if ({z_if_ack, z_d_ack, z_m_en, z_m_we, z_m_addr, z_if_rdata, z_d_rdata} !== '0) begin
         errors++;
         $display("FAIL reset_ws0_outputs got en=%b we=%b addr=%h exp all zero", z_m_en, z_m_we, z_m_addr);
      end
      reset = 1'b0;
   endtask

   task automatic test_fetch();
      if_req  = 1'b1;
      if_addr = 32'h10;
      #1;
      for (int c = 0; c <= 5; c++) begin
         logic exp_en;
         exp_en = (c >= 1 && c <= 3);
         checks++;
         if (m_en !== exp_en) begin errors++; $display("FAIL fetch_en c%0d got %b exp %b", c, m_en, exp_en); end
         checks++;
         if (if_ack !== (c == 4)) begin errors++; $display("FAIL fetch_ack c%0d got %b exp %b", c, if_ack, (c == 4)); end
         checks++;
         if (stall !== (c <= 3)) begin errors++; $display("FAIL fetch_stall c%0d got %b exp %b", c, stall, (c <= 3)); end
         checks++;
         if (m_we !== 1'b0) begin errors++; $display("FAIL fetch_we c%0d got %b exp 0", c, m_we); end
         if (exp_en) begin
            checks++;
            if (m_addr !== 32'h10) begin errors++; $display("FAIL fetch_addr c%0d got %h exp 00000010", c, m_addr); end
         end
         if (c == 2) if_addr = 32'hFFFF_FFF0;
         if (c == 4) begin
            checks++;
            if (if_rdata !== 32'h2108_000A) begin errors++; $display("FAIL fetch_rdata got %h exp 2108000a", if_rdata); end
            if_req = 1'b0;
         end
         tick();
      end
   endtask

   task automatic test_store();
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF; d_bsel = 2'b00;
      #1;
      for (int c = 0; c <= 5; c++) begin
         checks++;
         if (m_we !== (c == 3)) begin errors++; $display("FAIL store_we c%0d got %b exp %b", c, m_we, (c == 3)); end
         checks++;
         if (d_ack !== (c == 4)) begin errors++; $display("FAIL store_ack c%0d got %b exp %b", c, d_ack, (c == 4)); end
         if (c == 1) begin d_wdata = 32'h0; d_addr = 32'h80; end
         if (c == 3) begin
            checks++;
            if (m_addr !== 32'h40 || m_wdata !== 32'hDEAD_BEEF || m_bsel !== 2'b00) begin
               errors++;
               $display("FAIL store_bus got addr=%h wdata=%h bsel=%b exp 00000040 deadbeef 00", m_addr, m_wdata, m_bsel);
            end
         end
         if (c == 4) d_req = 1'b0;
         tick();
      end
      checks++;
      if (ram[16] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_mem got %h exp deadbeef", ram[16]); end
   endtask

   task automatic test_simultaneous();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8; d_bsel = 2'b10;
      if_req = 1'b1; if_addr = 32'h14;
      #1;
      for (int c = 0; c <= 8; c++) begin
         checks++;
         if (d_ack !== (c == 4)) begin errors++; $display("FAIL sim_mem_ack c%0d got %b exp %b", c, d_ack, (c == 4)); end
         checks++;
         if (if_ack !== (c == 7)) begin errors++; $display("FAIL sim_if_ack c%0d got %b exp %b", c, if_ack, (c == 7)); end
         checks++;
         if (stall !== (c <= 6)) begin errors++; $display("FAIL sim_stall c%0d got %b exp %b", c, stall, (c <= 6)); end
         checks++;
         if (m_en !== (c >= 1 && c <= 6)) begin errors++; $display("FAIL sim_en c%0d got %b exp %b", c, m_en, (c >= 1 && c <= 6)); end
         if (c == 2) begin
            checks++;
            if (m_addr !== 32'h8 || m_bsel !== 2'b10) begin errors++; $display("FAIL sim_mem_bus got %h %b exp 00000008 10", m_addr, m_bsel); end
         end
         if (c == 5) begin
            checks++;
            if (m_addr !== 32'h14 || m_bsel !== 2'b00) begin errors++; $display("FAIL sim_if_bus got %h %b exp 00000014 00", m_addr, m_bsel); end
         end
         if (c == 4) begin
            checks++;
            if (d_rdata !== init_word(2)) begin errors++; $display("FAIL sim_mem_rdata got %h exp %h", d_rdata, init_word(2)); end
            d_req = 1'b0;
         end
         if (c == 7) begin
            checks++;
            if (if_rdata !== init_word(5)) begin errors++; $display("FAIL sim_if_rdata got %h exp %h", if_rdata, init_word(5)); end
            if_req = 1'b0;
         end
         tick();
      end
   endtask

   // Starting with IF as last grant, both held high: MEM, IF, MEM, IF, MEM spaced WS+1 apart.
   task automatic test_alternation();
      int drop_c;
      drop_c = (WS + 2) + 3 * (WS + 1);
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0; if_req = 1'b1; if_addr = 32'h4;
      #1;
      for (int c = 0; c <= drop_c + WS + 5; c++) begin
         logic exp_if, exp_d;
         int k;
         exp_if = 1'b0;
         exp_d  = 1'b0;
         if (c >= WS + 2 && (c - (WS + 2)) % (WS + 1) == 0) begin
            k = (c - (WS + 2)) / (WS + 1);
            if (k <= 4) begin
               exp_d  = (k % 2 == 0);
               exp_if = (k % 2 == 1);
            end
         end
         checks++;
         if (if_ack !== exp_if || d_ack !== exp_d) begin
            errors++;
            $display("FAIL alt_order c%0d got if=%b mem=%b exp if=%b mem=%b", c, if_ack, d_ack, exp_if, exp_d);
         end
         if (c == drop_c) begin d_req = 1'b0; if_req = 1'b0; end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'h1234_5678; d_bsel = 2'b01;
      #1;
      for (int c = 0; c <= 6; c++) begin
         checks++;
         if (m_we !== 1'b0 || d_ack !== 1'b0) begin errors++; $display("FAIL rstmid_we_ack c%0d got we=%b ack=%b exp 0 0", c, m_we, d_ack); end
         if (c == 2) begin reset = 1'b1; d_req = 1'b0; end
         if (c == 3) begin
            checks++;
            if ({if_ack, d_ack, m_en, m_we, if_rdata, d_rdata, m_addr, m_wdata, m_bsel} !== '0) begin
               errors++;
               $display("FAIL rstmid_outputs got en=%b addr=%h wdata=%h bsel=%b exp all zero", m_en, m_addr, m_wdata, m_bsel);
            end
            reset = 1'b0;
         end
         tick();
      end
   endtask

   task automatic test_ws0();
      z_d_req = 1'b1; z_d_we = 1'b0; z_d_addr = 32'h8; z_m_rdata = 32'h5;
      #1;
      for (int c = 0; c <= 3; c++) begin
         checks++;
         if (z_d_ack !== (c == 2)) begin errors++; $display("FAIL ws0_ack c%0d got %b exp %b", c, z_d_ack, (c == 2)); end
         checks++;
         if (z_m_en !== (c == 1)) begin errors++; $display("FAIL ws0_en c%0d got %b exp %b", c, z_m_en, (c == 1)); end
         if (c == 0) begin
            checks++;
            if (z_stall !== 1'b1) begin errors++; $display("FAIL ws0_stall got %b exp 1", z_stall); end
         end
         if (c == 1) begin
            checks++;
            if (z_m_addr !== 32'h8) begin errors++; $display("FAIL ws0_addr got %h exp 00000008", z_m_addr); end
         end
         if (c == 2) begin
            checks++;
            if (z_d_rdata !== 32'h5) begin errors++; $display("FAIL ws0_rdata got %h exp 00000005", z_d_rdata); end
            z_d_req = 1'b0;
         end
         tick();
      end
      // Last grant is now MEM, so IF wins the pair and the store follows with no gap.
      z_m_rdata = 32'h7;
      z_if_req = 1'b1; z_if_addr = 32'h20;
      z_d_req = 1'b1; z_d_we = 1'b1; z_d_addr = 32'h30; z_d_wdata = 32'hCAFE_0001; z_d_bsel = 2'b11;
      #1;
      for (int c = 0; c <= 4; c++) begin
         checks++;
         if (z_if_ack !== (c == 2) || z_d_ack !== (c == 3)) begin
            errors++;
            $display("FAIL ws0_pair_ack c%0d got if=%b mem=%b exp if=%b mem=%b", c, z_if_ack, z_d_ack, (c == 2), (c == 3));
         end
         checks++;
         if (z_m_we !== (c == 2)) begin errors++; $display("FAIL ws0_pair_we c%0d got %b exp %b", c, z_m_we, (c == 2)); end
         checks++;
         if (z_m_en !== (c >= 1 && c <= 2)) begin errors++; $display("FAIL ws0_pair_en c%0d got %b exp %b", c, z_m_en, (c >= 1 && c <= 2)); end
         if (c == 2) begin
            checks++;
            if (z_if_rdata !== 32'h7 || z_m_wdata !== 32'hCAFE_0001 || z_m_bsel !== 2'b11) begin
               errors++;
               $display("FAIL ws0_pair_data got rdata=%h wdata=%h bsel=%b exp 00000007 cafe0001 11", z_if_rdata, z_m_wdata, z_m_bsel);
            end
            z_if_req = 1'b0;
         end
         if (c == 3) z_d_req = 1'b0;
         tick();
      end
   endtask

   // Reference: accesses are serial, so memory contents follow store completions in Ack order.
   task automatic test_random();
      logic [31:0] model [0:15];
      logic        if_busy, d_busy, d_store;
      int          if_idx, d_idx, if_start, d_start, issued, acked;
      logic [31:0] d_data;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 16; i++) model[i] = init_word(i);
      if_busy = 1'b0; d_busy = 1'b0; d_store = 1'b0; d_data = '0;
      if_idx = 0; d_idx = 0; if_start = 0; d_start = 0; issued = 0; acked = 0;
      for (int cyc = 0; cyc < 820; cyc++) begin
         checks++;
         if (if_ack && d_ack) begin errors++; $display("FAIL rand_both_ack c%0d got 1 1 exp at most one", cyc); end
         checks++;
         if (stall !== ((if_req & ~if_ack) | (d_req & ~d_ack))) begin
            errors++;
            $display("FAIL rand_stall c%0d got %b exp %b", cyc, stall, (if_req & ~if_ack) | (d_req & ~d_ack));
         end
         if (if_ack) begin
            checks++;
            if (!if_busy) begin errors++; $display("FAIL rand_if_spurious c%0d got ack exp none", cyc); end
            else if (if_rdata !== model[if_idx] || cyc - if_start < WS + 2) begin
               errors++;
               $display("FAIL rand_if_data c%0d got %h lat %0d exp %h lat>=%0d", cyc, if_rdata, cyc - if_start, model[if_idx], WS + 2);
            end
            if_busy = 1'b0;
            acked++;
         end
         if (d_ack) begin
            checks++;
            if (!d_busy) begin errors++; $display("FAIL rand_mem_spurious c%0d got ack exp none", cyc); end
            else if ((!d_store && d_rdata !== model[d_idx]) || cyc - d_start < WS + 2) begin
               errors++;
               $display("FAIL rand_mem_data c%0d got %h lat %0d exp %h lat>=%0d", cyc, d_rdata, cyc - d_start, model[d_idx], WS + 2);
            end
            if (d_busy && d_store) model[d_idx] = d_data;
            d_busy = 1'b0;
            acked++;
         end
         if (if_busy && cyc - if_start > LIMIT) begin
            checks++; errors++; if_busy = 1'b0;
            $display("FAIL rand_if_timeout c%0d got no ack exp within %0d", cyc, LIMIT);
         end
         if (d_busy && cyc - d_start > LIMIT) begin
            checks++; errors++; d_busy = 1'b0;
            $display("FAIL rand_mem_timeout c%0d got no ack exp within %0d", cyc, LIMIT);
         end
         if (cyc < 800 && !if_busy && $urandom_range(0, 2) == 0) begin
            if_busy = 1'b1; if_idx = int'($urandom_range(0, 15)); if_start = cyc; issued++;
            if_addr = 32'(if_idx) << 2;
         end
         if (cyc < 800 && !d_busy && $urandom_range(0, 2) == 0) begin
            d_busy = 1'b1; d_idx = int'($urandom_range(0, 15)); d_start = cyc; issued++;
            d_store = 1'($urandom_range(0, 1)); d_data = $urandom;
            d_addr = 32'(d_idx) << 2; d_we = d_store; d_wdata = d_data; d_bsel = 2'($urandom_range(0, 3));
         end
         if_req = if_busy;
         d_req  = d_busy;
         tick();
      end
      checks++;
      if (acked !== issued) begin errors++; $display("FAIL rand_count got %0d acks exp %0d", acked, issued); end
   endtask

   initial begin
      reset = 1'b1;
      if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_bsel = 2'b00;
      z_if_req = 1'b0; z_if_addr = '0; z_d_req = 1'b0; z_d_we = 1'b0; z_d_addr = '0; z_d_wdata = '0;
      z_d_bsel = 2'b00; z_m_rdata = '0;
      test_reset();
      test_fetch();
      test_store();
      test_simultaneous();
      test_alternation();
      test_reset_mid();
      test_ws0();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port instruction/data memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipeline.
- Sequences each access over a configurable number of wait states and returns data with a one-cycle Ack pulse.
- Drives a pipeline-wide stall while any request is outstanding.
- Sits between IF_STAGE/MEM_STAGE and the shared memory macro; clocked by the divided CPU clock.

Parameters:
- WAIT_STATES, 2, number of extra memory cycles per access; legal range 0..15.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- Clock  in  1  CPU clock (divided clock).
- Reset  in  1  synchronous reset, active-high.
- IF_Req  in  1  fetch request; held until IF_Ack.
- IF_Addr  in  AW  fetch address.
- IF_RData  out  DW  fetched instruction; valid when IF_Ack=1.
- IF_Ack  out  1  one-cycle fetch-complete pulse.
- MEM_Req  in  1  data request; held until MEM_Ack.
- MEM_We  in  1  1=store, 0=load.
- MEM_Addr  in  AW  data address.
- MEM_WData  in  DW  store data.
- MEM_ByteSel  in  2  access size, passed through unchanged.
- MEM_RData  out  DW  load data; valid when MEM_Ack=1.
- MEM_Ack  out  1  one-cycle data-complete pulse.
- Stall  out  1  pipeline freeze: (IF_Req & ~IF_Ack) | (MEM_Req & ~MEM_Ack); combinational.
- Mem_En  out  1  memory enable.
- Mem_We  out  1  memory write strobe.
- Mem_Addr  out  AW  memory address.
- Mem_WData  out  DW  memory write data.
- Mem_ByteSel  out  2  memory access size.
- Mem_RData  in  DW  memory read data; valid during the final access cycle.

Behaviour:
- Clock/reset: one clock. Reset is synchronous and active-high; port names are Clock and Reset.
- Reset values: state=IDLE, cnt=0, last_grant=IF, IF_Ack=0, MEM_Ack=0, IF_RData=0, MEM_RData=0, Mem_En=0, Mem_We=0, Mem_Addr=0, Mem_WData=0, Mem_ByteSel=0.
- FSM states: IDLE, BUSY_IF, BUSY_MEM. All outputs are registered except Stall.
- Grant rule when both requests are eligible:
  - MEM wins, unless last_grant=MEM and IF_Req=1; then IF wins.
  - With both requests continuously asserted, grants alternate.
  - last_grant updates on every grant.
- Grant from IDLE:
  - On the edge where a request is sampled, enter BUSY_x with cnt=WAIT_STATES.
  - Latch Addr, WData, We and ByteSel into the Mem_* registers.
  - Mem_En=1 from the next cycle.
- BUSY_x:
  - Mem_* outputs hold their values.
  - cnt decrements each cycle until it reaches 0.
  - Mem_We=1 only in the cnt==0 cycle of a BUSY_MEM store, giving a single-cycle write strobe. Mem_We=0 otherwise, and always 0 for fetches.
- Completion, on the edge where cnt==0:
  - Capture Mem_RData into x_RData (stores also capture it; the value is don't-care).
  - x_Ack=1 for exactly the next cycle.
  - Re-arbitrate in the same edge. The completing requester is excluded, because its Req is still high. If the other requester is pending, go directly to its BUSY state (no idle bubble). Otherwise go to IDLE.
  - Mem_En stays 1 across a back-to-back transition.
- Latency: Req sampled in IDLE at cycle 0 gives Ack at cycle WAIT_STATES+2. Default: Ack at cycle 4. WAIT_STATES=0: Ack at cycle 2.
- Boundary conditions:
  - Req dropped mid-access: the access still completes and Ack still pulses. A store is still written.
  - Req re-asserted in the Ack cycle: treated as a new request and arbitrated on the following edge.
  - Address/data changes during BUSY are ignored (values are latched).
  - Both Acks are never high in the same cycle.
  - Reset mid-access: abort immediately. An in-flight store must not produce a Mem_We pulse after Reset is sampled.
  - Stall deasserts in the Ack cycle when no other request is outstanding.

Test Plan:
- Fetch only, WAIT_STATES=2: IF_Req=1, IF_Addr=0x00000010 at cycle 0, Mem_RData=0x2108000A at cycle 3 -> Mem_En cycles 1-3; IF_Ack=1 and IF_RData=0x2108000A only at cycle 4; Stall=1 cycles 0-3, 0 at cycle 4.
- Store: MEM_Req=1, MEM_We=1, MEM_Addr=0x40, MEM_WData=0xDEADBEEF, MEM_ByteSel=2'b00 -> Mem_We=1 exactly one cycle (cycle 3) with Mem_Addr=0x40, Mem_WData=0xDEADBEEF; MEM_Ack at cycle 4.
- Simultaneous requests, last_grant=IF after reset: IF_Req=MEM_Req=1 at cycle 0 -> MEM served first (MEM_Ack at cycle 4); BUSY_IF entered with no IDLE gap; IF_Ack at cycle 7; Stall=1 cycles 0-6.
- Both requests held high and each re-asserted immediately after its Ack -> grant order MEM, IF, MEM, IF; no requester is acked twice in a row.
- Reset asserted at cycle 2 of a store -> no Mem_We pulse; every output at its reset value from cycle 3; MEM_Ack never asserts.
- WAIT_STATES=0 build: load from 0x8 with Mem_RData=0x5 -> MEM_Ack and MEM_RData=0x5 at cycle 2; back-to-back IF+MEM pair completes by cycle 3.
